// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the EX-stage forwarding / hazard controller:
//   - REC_AW      : register address width carried in a stage record
//   - FWD_RF/WB/MEM: operand mux select encodings (2'b11 is never used)
//   - stage_rec_t : per-stage shadow record copied from the ID decode fields
// ---------------------------------------------------------------------------
package fwd_pkg;

  localparam int REC_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rs;
    logic [REC_AW-1:0] rt;
    logic [REC_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_rec_t;

endpackage

// File: rtl/fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Priority comparator for one operand mux. The MEM record is newer than the
// WB record, so a MEM match wins. r0 is hard-wired zero and never forwards.
// Ports:
//   src_i     in  source register of the instruction in EX
//   mem_rec_i in  EX/MEM shadow record
//   wb_rec_i  in  MEM/WB shadow record
//   sel_o     out mux select (FWD_RF / FWD_WB / FWD_MEM)
// ---------------------------------------------------------------------------
module fwd_sel
  import fwd_pkg::*;
(
  input  logic [REC_AW-1:0] src_i,
  input  stage_rec_t        mem_rec_i,
  input  stage_rec_t        wb_rec_i,
  output logic [1:0]        sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_rec_i.valid && mem_rec_i.regwrite &&
                   (mem_rec_i.rd != '0) && (mem_rec_i.rd == src_i);
  assign wb_hit  = wb_rec_i.valid && wb_rec_i.regwrite &&
                   (wb_rec_i.rd != '0) && (wb_rec_i.rd == src_i);

  always_comb begin
    if (mem_hit)     sel_o = FWD_MEM;
    else if (wb_hit) sel_o = FWD_WB;
    else             sel_o = FWD_RF;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// EX-stage forwarding and pipeline hold controller. Keeps EX/MEM/WB shadow
// records of the ID decode fields, drives both operand mux selects, inserts
// one bubble per load-use hazard, and freezes with the pipeline on a dcache
// stall. REG_AW must equal fwd_pkg::REC_AW (the record field width).
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_valid_i .. id_memread_i  ID-stage decode fields
//   flush_i                 branch taken, squash the ID instruction
//   mem_stall_i             dcache miss, whole pipeline frozen
//   fwd_a_o, fwd_b_o        operand A/B mux selects
//   pc_hold_o               hold PC and IF/ID
//   pipe_hold_o             hold ID/EX, EX/MEM, MEM/WB
//   lu_stall_cnt_o          saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = REC_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              pc_hold_o,
  output logic              pipe_hold_o,
  output logic [CNT_W-1:0]  lu_stall_cnt_o
);

  stage_rec_t       ex_q,  ex_d;
  stage_rec_t       mem_q, mem_d;
  stage_rec_t       wb_q,  wb_d;
  stage_rec_t       id_rec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic [1:0]       sel_a, sel_b;

  assign id_rec = '{valid:    id_valid_i,
                    rs:       id_rs_i,
                    rt:       id_rt_i,
                    rd:       id_rd_i,
                    regwrite: id_regwrite_i,
                    memread:  id_memread_i};

  // Load in EX whose result is needed by the ID instruction: the value only
  // exists after MEM, so ID must wait one cycle behind a bubble.
  assign lu = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
              ((ex_q.rd == id_rs_i) || (id_rt_used_i && (ex_q.rd == id_rt_i)));

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so that no
    // path through the block leaves it unassigned (no latch is inferred).
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!mem_stall_i) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (lu || flush_i) ex_d = '0;
      else               ex_d = id_rec;
      if (lu && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. All record
    // fields are cleared on reset, not just valid, so no stale rd or
    // memread can leak into a compare after reset.
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_sel u_sel_a (
    .src_i     (ex_q.rs),
    .mem_rec_i (mem_q),
    .wb_rec_i  (wb_q),
    .sel_o     (sel_a)
  );

  fwd_sel u_sel_b (
    .src_i     (ex_q.rt),
    .mem_rec_i (mem_q),
    .wb_rec_i  (wb_q),
    .sel_o     (sel_b)
  );

  // A bubble in EX reads nothing, so its selects rest at the register file.
  assign fwd_a_o        = ex_q.valid ? sel_a : FWD_RF;
  assign fwd_b_o        = ex_q.valid ? sel_b : FWD_RF;
  assign pc_hold_o      = lu | mem_stall_i;
  assign pipe_hold_o    = mem_stall_i;
  assign lu_stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
// Directed scenarios plus randomized instruction streams, every cycle
// compared against a small pipeline model (array of EX/MEM/WB entries).
// The DUT is built with a 2-bit stall counter so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt, rd;
    bit       rtu, rw, mr;
  } instr_t;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt, rd;
    bit       rw, mr;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_i, id_valid_i, id_rt_used_i, id_regwrite_i, id_memread_i;
  logic          flush_i, mem_stall_i;
  logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
  logic [1:0]    fwd_a_o, fwd_b_o;
  logic          pc_hold_o, pipe_hold_o;
  logic [CW-1:0] lu_stall_cnt_o;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_rt_used_i   (id_rt_used_i),
    .id_rd_i        (id_rd_i),
    .id_regwrite_i  (id_regwrite_i),
    .id_memread_i   (id_memread_i),
    .flush_i        (flush_i),
    .mem_stall_i    (mem_stall_i),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o),
    .pc_hold_o      (pc_hold_o),
    .pipe_hold_o    (pipe_hold_o),
    .lu_stall_cnt_o (lu_stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: index 0 = EX, 1 = MEM, 2 = WB
  rec_t   mdl[3];
  int     mdl_cnt;

  // stimulus globals
  instr_t cur;
  bit     s_flush, s_stall, s_rst;

  // per-tick observations and model decisions
  int     obs_a, obs_b, obs_hold, obs_phold, obs_cnt;
  bit     last_adv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit rtu,
                                bit [4:0] rd, bit rw, bit mr);
    instr_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.rtu = rtu; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  // Newest producer (MEM before WB) that writes src wins; r0 never forwards.
  function automatic int ref_fwd(bit [4:0] src);
    if (!mdl[0].v) return 0;
    for (int k = 1; k <= 2; k++)
      if (mdl[k].v && mdl[k].rw && mdl[k].rd != 0 && mdl[k].rd == src)
        return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit ref_lu();
    return mdl[0].v && mdl[0].mr && mdl[0].rd != 0 && cur.v &&
           (mdl[0].rd == cur.rs || (cur.rtu && mdl[0].rd == cur.rt));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) mdl[k] = '{default: 0};
    mdl_cnt = 0;
  endtask

  // One clock cycle: drive, compare all outputs against the model, advance.
  task automatic tick();
    bit   lu;
    int   ea, eb;
    rec_t nx[3];
    int   ncnt;
    @(negedge clk);
    rst_i         = s_rst;
    flush_i       = s_flush;
    mem_stall_i   = s_stall;
    id_valid_i    = cur.v;
    id_rs_i       = cur.rs;
    id_rt_i       = cur.rt;
    id_rt_used_i  = cur.rtu;
    id_rd_i       = cur.rd;
    id_regwrite_i = cur.rw;
    id_memread_i  = cur.mr;
    #1;
    lu = ref_lu();
    ea = ref_fwd(mdl[0].rs);
    eb = ref_fwd(mdl[0].rt);
    obs_a     = int'(fwd_a_o);
    obs_b     = int'(fwd_b_o);
    obs_hold  = int'(pc_hold_o);
    obs_phold = int'(pipe_hold_o);
    obs_cnt   = int'(lu_stall_cnt_o);
    check("fwd_a", 32'(fwd_a_o), 32'(ea));
    check("fwd_b", 32'(fwd_b_o), 32'(eb));
    check("pc_hold", 32'(pc_hold_o), 32'(lu | s_stall));
    check("pipe_hold", 32'(pipe_hold_o), 32'(s_stall));
    check("lu_cnt", 32'(lu_stall_cnt_o), 32'(mdl_cnt));
    // a load sitting in MEM must never be the forward source for rs
    check("no_load_fwd", 32'(fwd_a_o == 2'b10 && mdl[1].mr), 32'd0);
    last_adv = !s_stall && (!lu || s_flush);
    nx   = mdl;
    ncnt = mdl_cnt;
    if (s_rst) begin
      for (int k = 0; k < 3; k++) nx[k] = '{default: 0};
      ncnt = 0;
    end else if (!s_stall) begin
      nx[2] = mdl[1];
      nx[1] = mdl[0];
      if (lu || s_flush) nx[0] = '{default: 0};
      else nx[0] = '{v: cur.v, rs: cur.rs, rt: cur.rt, rd: cur.rd, rw: cur.rw, mr: cur.mr};
      if (lu && ncnt < CNT_MAX) ncnt++;
    end
    @(posedge clk);
    mdl     = nx;
    mdl_cnt = ncnt;
  endtask

  // Present an instruction until the ID stage accepts it.
  task automatic issue(input instr_t i);
    int guard = 0;
    cur = i;
    tick();
    while (!last_adv && guard < 20) begin
      tick();
      guard++;
    end
    check("issue_timeout", 32'(guard >= 20), 32'd0);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    cur   = nop();
    tick();
    s_rst = 1'b0;
  endtask

  instr_t add_r3, lw_r2, use_r2;
  int     cnt_before;
  int     phold_cycles;

  initial begin
    s_rst = 1'b1; s_flush = 1'b0; s_stall = 1'b0; cur = nop();
    rst_i = 1'b1; flush_i = 1'b0; mem_stall_i = 1'b0;
    id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rt_used_i = 1'b0;
    id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    s_rst = 1'b0;

    // reset state
    cur = nop();
    tick();
    check("rst_fwd_a", 32'(obs_a), 32'd0);
    check("rst_fwd_b", 32'(obs_b), 32'd0);
    check("rst_pc_hold", 32'(obs_hold), 32'd0);
    check("rst_cnt", 32'(obs_cnt), 32'd0);

    add_r3 = mk(1, 5'd1, 5'd2, 1, 5'd3, 1, 0);
    lw_r2  = mk(1, 5'd1, 5'd0, 0, 5'd2, 1, 1);
    use_r2 = mk(1, 5'd2, 5'd1, 1, 5'd7, 1, 0);

    // EX->EX forward
    issue(add_r3);
    issue(mk(1, 5'd3, 5'd1, 1, 5'd4, 1, 0));
    cur = nop(); tick();
    check("exex_fwd_a", 32'(obs_a), 32'd2);
    check("exex_no_hold", 32'(obs_hold), 32'd0);

    // WB forward on operand B
    do_reset();
    issue(add_r3);
    issue(nop());
    issue(mk(1, 5'd0, 5'd3, 1, 5'd5, 1, 0));
    cur = nop(); tick();
    check("wb_fwd_b", 32'(obs_b), 32'd1);
    check("wb_fwd_a_r0", 32'(obs_a), 32'd0);

    // MEM beats WB
    do_reset();
    issue(add_r3);
    issue(add_r3);
    issue(mk(1, 5'd3, 5'd3, 1, 5'd6, 1, 0));
    cur = nop(); tick();
    check("prio_fwd_a", 32'(obs_a), 32'd2);
    check("prio_fwd_b", 32'(obs_b), 32'd2);

    // load-use: one hold cycle, one bubble, then WB forward
    do_reset();
    issue(lw_r2);
    cur = use_r2; tick();
    check("lu_hold1", 32'(obs_hold), 32'd1);
    tick();
    check("lu_hold2", 32'(obs_hold), 32'd0);
    cur = nop(); tick();
    check("lu_fwd_a", 32'(obs_a), 32'd1);
    check("lu_cnt1", 32'(obs_cnt), 32'd1);

    // r0 load never stalls or forwards
    do_reset();
    issue(mk(1, 5'd1, 5'd0, 0, 5'd0, 1, 1));
    cur = mk(1, 5'd0, 5'd0, 1, 5'd7, 1, 0); tick();
    check("r0_no_hold", 32'(obs_hold), 32'd0);
    cur = nop(); tick();
    check("r0_fwd_a", 32'(obs_a), 32'd0);
    check("r0_fwd_b", 32'(obs_b), 32'd0);

    // rt match with rt unused: no stall
    issue(lw_r2);
    cur = mk(1, 5'd1, 5'd2, 0, 5'd2, 1, 0); tick();
    check("rtunused_no_hold", 32'(obs_hold), 32'd0);

    // dcache stall during a forwarding case
    do_reset();
    issue(add_r3);
    issue(mk(1, 5'd3, 5'd1, 1, 5'd4, 1, 0));
    s_stall = 1'b1; cur = nop();
    phold_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_fwd_a", 32'(obs_a), 32'd2);
      phold_cycles += obs_phold;
    end
    check("stall_phold_cycles", 32'(phold_cycles), 32'd10);
    check("stall_cnt", 32'(obs_cnt), 32'd0);
    s_stall = 1'b0; tick();
    check("stall_release_fwd_a", 32'(obs_a), 32'd2);

    // load-use arriving during a stall: bubble only after the stall drops
    do_reset();
    issue(lw_r2);
    s_stall = 1'b1; cur = use_r2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lustall_hold", 32'(obs_hold), 32'd1);
      check("lustall_cnt", 32'(obs_cnt), 32'd0);
    end
    s_stall = 1'b0; tick();
    check("lustall_lu", 32'(obs_hold), 32'd1);
    tick();
    check("lustall_accept", 32'(obs_hold), 32'd0);
    cur = nop(); tick();
    check("lustall_cnt1", 32'(obs_cnt), 32'd1);

    // reset mid-operation with all three records valid
    issue(mk(1, 5'd1, 5'd1, 1, 5'd3, 1, 0));
    issue(mk(1, 5'd3, 5'd3, 1, 5'd4, 1, 0));
    issue(mk(1, 5'd4, 5'd3, 1, 5'd5, 1, 0));
    s_rst = 1'b1; cur = mk(1, 5'd5, 5'd4, 1, 5'd6, 1, 0); tick();
    s_rst = 1'b0; cur = nop(); tick();
    check("midrst_fwd_a", 32'(obs_a), 32'd0);
    check("midrst_fwd_b", 32'(obs_b), 32'd0);
    check("midrst_hold", 32'(obs_hold), 32'd0);
    check("midrst_cnt", 32'(obs_cnt), 32'd0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(lw_r2);
      issue(use_r2);
    end
    cur = nop(); tick();
    check("sat_cnt", 32'(obs_cnt), 32'(CNT_MAX));

    // randomized streams with flushes, stalls and occasional resets
    do_reset();
    last_adv = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (last_adv) begin
        cur = mk($urandom_range(99) < 85, 5'($urandom_range(7)), 5'($urandom_range(7)),
                 1'($urandom_range(1)), 5'($urandom_range(7)),
                 $urandom_range(99) < 80, $urandom_range(99) < 30);
      end
      s_stall = $urandom_range(99) < 15;
      s_flush = $urandom_range(99) < 10;
      s_rst   = $urandom_range(99) < 2;
      tick();
      if (s_rst) last_adv = 1'b1;
    end
    s_stall = 1'b0; s_flush = 1'b0; s_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Sequencing controller for the EX-stage operand forwarding muxes and pipeline hold logic in the dcache pipelined CPU.
- Keeps its own EX/MEM/WB shadow records of destination register, regwrite and memread, copied from the ID-stage decode fields.
- From those records it drives the 2-bit select of both operand muxes, detects load-use hazards, inserts bubbles, and freezes on dcache stall.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and takes the same hold condition they do.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_rs_i  in  REG_AW  ID source register A.
- id_rt_i  in  REG_AW  ID source register B.
- id_rt_used_i  in  1  ID instruction reads rt (R-type, store, branch).
- id_rd_i  in  REG_AW  ID destination register (already muxed rt/rd).
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  branch taken; ID instruction is squashed.
- mem_stall_i  in  1  dcache miss in progress; whole pipeline frozen.
- fwd_a_o  out  2  operand A mux select.
- fwd_b_o  out  2  operand B mux select.
- pc_hold_o  out  1  hold PC and IF/ID register.
- pipe_hold_o  out  1  hold ID/EX, EX/MEM and MEM/WB registers (= mem_stall_i).
- lu_stall_cnt_o  out  CNT_W  saturating count of load-use bubble cycles.

Behaviour:
- Stage record fields: valid, rs, rt, rd, regwrite, memread. Internal records are EX, MEM and WB.
- Reset (synchronous, rst_i=1 at the edge):
  - all records valid=0 and other fields 0; counter 0.
  - Outputs after reset: fwd_a_o=fwd_b_o=2'b00, pc_hold_o=0, pipe_hold_o follows mem_stall_i.
  - rst_i overrides mem_stall_i and flush_i.
- Load-use hazard (combinational), lu is true when all of these hold:
  - EX.valid, EX.memread and EX.rd != 0;
  - id_valid_i;
  - EX.rd == id_rs_i, or (id_rt_used_i and EX.rd == id_rt_i).
- Record update each edge, when mem_stall_i=0:
  - WB<=MEM and MEM<=EX.
  - EX <= bubble (valid=0) if lu or flush_i; otherwise EX <= ID fields, with valid = id_valid_i.
- Record update when mem_stall_i=1: all records hold, no bubble is inserted, counter holds. mem_stall_i dominates lu and flush_i.
- pc_hold_o = lu | mem_stall_i.
- Forwarding select, per operand (src = EX.rs for A, EX.rt for B). Priority MEM over WB, so the newest value wins:
  - 2'b10 if MEM.valid & MEM.regwrite & MEM.rd != 0 & MEM.rd == src;
  - else 2'b01 if WB.valid & WB.regwrite & WB.rd != 0 & WB.rd == src;
  - else 2'b00 (register file).
  - Selects are combinational from the registered records only (no input-to-output path) and are valid in the same cycle the instruction occupies EX.
  - 2'b11 is never driven; any 2'b11 is a design error.
  - If EX.valid=0, both selects are 2'b00.
  - During mem_stall_i the records are frozen, so the selects stay stable for the whole stall.
- A load in MEM matching EX.src cannot occur, because lu guarantees a bubble between them. The bench checks this invariant.
- r0 never forwards and never causes a stall.
- Counter: increments when lu=1 and mem_stall_i=0; saturates at 2^CNT_W-1 and does not wrap.
- lu together with flush_i: the bubble is inserted once; the counter still counts.

Decomposition:
- Shared package `fwd_pkg`:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - struct `stage_rec_t` (valid, rs, rt, rd, regwrite, memread), used by the hazard logic and any trace monitor.
- Sub-module `fwd_sel`: pure priority comparator (src, MEM record, WB record -> 2-bit select). It is instantiated twice, once for A and once for B.

Test Plan:
- EX→EX forward: add r3 then sub r4,r3,r1 back to back, no stall -> fwd_a_o=2'b10 in the cycle sub is in EX; pc_hold_o stays 0.
- MEM/WB forward and priority:
  - add r3, nop, or r5,r0,r3 -> fwd_b_o=2'b01;
  - add r3, add r3, and r6,r3,r3 -> fwd_a_o=fwd_b_o=2'b10 (newest wins).
- Load-use: lw r2 then add r7,r2,r1 -> pc_hold_o=1 for exactly 1 cycle, one bubble in EX, then fwd_a_o=2'b01; counter=1.
- r0 and unused rt:
  - lw r0 followed by a use of r0 -> no stall, selects 00;
  - lw r2 followed by addi reading r2 only in the rt field with id_rt_used_i=0 -> no stall.
- dcache stall:
  - mem_stall_i held high 10 cycles during a forwarding case -> records and selects frozen, pipe_hold_o=1 for 10 cycles, counter unchanged;
  - lw/use arriving during the stall -> the single bubble is inserted only after mem_stall_i drops.
- Reset mid-operation and saturation:
  - rst_i asserted with all three records valid -> next cycle selects 00, pc_hold_o=0, counter 0;
  - with CNT_W=2, five load-use hazards -> counter sticks at 3.
